// File: rtl/cv32e40p_pkg2_ft.sv
// Shared defaults and types for the instruction prefetch FIFO.
// The occupancy state is derived from the count, never stored separately from it.
package cv32e40p_pkg2_ft;

    localparam int unsigned PFF_DEPTH      = 4;
    localparam int unsigned PFF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        PFF_EMPTY   = 2'd0,
        PFF_PARTIAL = 2'd1,
        PFF_FULL    = 2'd2
    } pff_state_e;

    function automatic pff_state_e pff_state_from_count(input int unsigned count,
                                                        input int unsigned depth);
        pff_state_e state;
        if (count == 0) begin
            state = PFF_EMPTY;
        end else if (count >= depth) begin
            state = PFF_FULL;
        end else begin
            state = PFF_PARTIAL;
        end
        return state;
    endfunction

endpackage

// File: rtl/cv32e40p_prefetch_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count, EMPTY/PARTIAL/FULL state and flush for the
// prefetch FIFO. Handshakes depend only on registered state, never on out_ready_i.
module cv32e40p_prefetch_fifo_ptr_ctrl
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned DEPTH = PFF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1),
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic             wr_en_o,
    output logic             pop_o,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    pff_state_e       state_q, state_d;
    logic             push;
    logic             pop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of process ordering.
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            state_q <= PFF_EMPTY;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any same-cycle push or pop.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        state_d = pff_state_from_count(32'(count_d), DEPTH);
    end

    // Outputs, derived from registered state only.
    always_comb begin
        in_ready_o  = (state_q != PFF_FULL);
        out_valid_o = (state_q != PFF_EMPTY);
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        wr_en_o     = push & ~flush_i;
        pop_o       = pop;
        wptr_o      = wptr_q;
        rptr_o      = rptr_q;
        cnt_o       = count_q;
    end

endmodule

// File: rtl/cv32e40p_prefetch_fifo_ft.sv
// Instruction prefetch FIFO between the OBI response path and the IF-stage FSM.
// Define PREFETCH_FIFO_PARITY_EN to store a per-entry even-parity bit checked on pop.
module cv32e40p_prefetch_fifo_ft
    import cv32e40p_pkg2_ft::*;
#(
    parameter int unsigned DEPTH      = PFF_DEPTH,
    parameter int unsigned DATA_WIDTH = PFF_DATA_WIDTH,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_rdata_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_rdata_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  err_detected_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic                  wr_en;
    logic                  pop;
    logic                  par_err;

    cv32e40p_prefetch_fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .out_ready_i (out_ready_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .wr_en_o     (wr_en),
        .pop_o       (pop),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .cnt_o       (cnt_o)
    );

    // NOTE: the storage array has no reset; out_rdata_o is gated by out_valid_o, so
    // stale or unknown entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr] <= in_rdata_i;
        end
    end

    assign out_rdata_o = out_valid_o ? mem_q[rptr] : '0;

`ifdef PREFETCH_FIFO_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_q[wptr] <= ^in_rdata_i;
        end
    end

    // Recompute over the stored word; the flag is qualified by pop below.
    assign par_err = par_q[rptr] ^ (^mem_q[rptr]);
`else
    assign par_err = 1'b0;
`endif

    assign err_detected_o = pop & par_err;

endmodule
